// File: rtl/arm7tdmi_ptw_if.sv
// Descriptor-fetch bus between the page-table walker and memory.
// The master modport belongs to the walker; the slave modport belongs to the memory side.
interface arm7tdmi_ptw_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_abort;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_rdata,
      input  mem_ready,
      input  mem_abort
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_rdata,
      output mem_ready,
      output mem_abort
   );
endinterface

// File: rtl/arm7tdmi_ptw.sv
// ARMv4 two-level page-table walker. It fetches L1 section/coarse and L2 large/small
// descriptors, checks the domain, and returns a one-cycle TLB fill or a one-cycle fault.
module arm7tdmi_ptw #(
   parameter int ADDR_WIDTH = 32,
   parameter int ASID_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  walk_req,
   output logic                  walk_ready,
   input  logic [ADDR_WIDTH-1:0] walk_vaddr,
   input  logic [ASID_WIDTH-1:0] walk_asid,
   input  logic [31:0]           ttb_base,
   input  logic [31:0]           domain_access,
   input  logic                  walk_flush,
   arm7tdmi_ptw_if.master        mem,
   output logic                  fill_valid,
   output logic [ADDR_WIDTH-1:0] fill_vaddr,
   output logic [ADDR_WIDTH-1:0] fill_paddr,
   output logic [1:0]            fill_size,
   output logic [1:0]            fill_ap,
   output logic [3:0]            fill_domain,
   output logic                  fill_mgr,
   output logic                  fill_c,
   output logic                  fill_b,
   output logic [ASID_WIDTH-1:0] fill_asid,
   output logic                  fault_valid,
   output logic [3:0]            fault_status,
   output logic [ADDR_WIDTH-1:0] fault_addr,
   output logic [31:0]           walk_count,
   output logic [31:0]           fault_count
);

   typedef enum logic [2:0] {IDLE, L1, L2, RESP, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [31:0]           vaddr_q, vaddr_d;
   logic [ASID_WIDTH-1:0] asid_q, asid_d;
   logic [3:0]            domain_q, domain_d;
   logic                  discard_q, discard_d;
   logic                  mem_req_q, mem_req_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic                  fill_valid_q, fill_valid_d;
   logic [31:0]           fill_vaddr_q, fill_vaddr_d;
   logic [31:0]           fill_paddr_q, fill_paddr_d;
   logic [1:0]            fill_size_q, fill_size_d;
   logic [1:0]            fill_ap_q, fill_ap_d;
   logic [3:0]            fill_domain_q, fill_domain_d;
   logic                  fill_mgr_q, fill_mgr_d;
   logic                  fill_c_q, fill_c_d;
   logic                  fill_b_q, fill_b_d;
   logic [ASID_WIDTH-1:0] fill_asid_q, fill_asid_d;
   logic                  fault_valid_q, fault_valid_d;
   logic [3:0]            fault_status_q, fault_status_d;
   logic [31:0]           fault_addr_q, fault_addr_d;
   logic [31:0]           walk_count_q, walk_count_d;
   logic [31:0]           fault_count_q, fault_count_d;

   logic        res_fill, res_fault;
   logic [3:0]  res_status;
   logic [31:0] res_paddr;
   logic [1:0]  res_size, res_ap, res_field;
   logic [3:0]  res_domain;
   logic        res_c, res_b;
   logic        flush_now;
   logic [31:0] d;

   // Descriptor bits not used by any supported format, and the ignored TTB low bits.
   logic unused_bits;
   assign unused_bits = ^{ttb_base[13:0], mem.mem_rdata[9]};

   function automatic logic [1:0] dacr_field(input logic [31:0] dacr, input logic [3:0] dom);
      return dacr[{dom, 1'b0} +: 2];
   endfunction

   always_comb begin
      state_d        = state_q;
      vaddr_d        = vaddr_q;
      asid_d         = asid_q;
      domain_d       = domain_q;
      discard_d      = discard_q;
      mem_req_d      = mem_req_q;
      mem_addr_d     = mem_addr_q;
      fill_valid_d   = 1'b0;
      fill_vaddr_d   = fill_vaddr_q;
      fill_paddr_d   = fill_paddr_q;
      fill_size_d    = fill_size_q;
      fill_ap_d      = fill_ap_q;
      fill_domain_d  = fill_domain_q;
      fill_mgr_d     = fill_mgr_q;
      fill_c_d       = fill_c_q;
      fill_b_d       = fill_b_q;
      fill_asid_d    = fill_asid_q;
      fault_valid_d  = 1'b0;
      fault_status_d = fault_status_q;
      fault_addr_d   = fault_addr_q;
      walk_count_d   = walk_count_q;
      fault_count_d  = fault_count_q;
      res_fill       = 1'b0;
      res_fault      = 1'b0;
      res_status     = 4'h0;
      res_paddr      = 32'h0;
      res_size       = 2'b00;
      res_ap         = 2'b00;
      res_domain     = 4'h0;
      res_c          = 1'b0;
      res_b          = 1'b0;
      res_field      = 2'b00;
      d              = mem.mem_rdata;
      flush_now      = discard_q | walk_flush;

      case (state_q)
         IDLE: begin
            if (walk_req) begin
               vaddr_d    = walk_vaddr;
               asid_d     = walk_asid;
               discard_d  = 1'b0;
               mem_req_d  = 1'b1;
               mem_addr_d = {ttb_base[31:14], walk_vaddr[31:20], 2'b00};
               state_d    = L1;
            end
         end
         L1: begin
            discard_d = flush_now;
            if (mem.mem_ready) begin
               res_domain = d[8:5];
               res_field  = dacr_field(domain_access, d[8:5]);
               if (flush_now) begin
                  state_d   = DRAIN;
                  mem_req_d = 1'b0;
               end else if (mem.mem_abort) begin
                  res_fault  = 1'b1;
                  res_status = 4'hC;
               end else if (d[1:0] == 2'b00 || d[1:0] == 2'b11) begin
                  res_fault  = 1'b1;
                  res_status = 4'h5;
               end else if (d[1:0] == 2'b10) begin
                  if (!res_field[0]) begin
                     res_fault  = 1'b1;
                     res_status = 4'h9;
                  end else begin
                     res_fill  = 1'b1;
                     res_paddr = {d[31:20], 20'b0};
                     res_size  = 2'b00;
                     res_ap    = d[11:10];
                     res_c     = d[3];
                     res_b     = d[2];
                  end
               end else begin
                  domain_d   = d[8:5];
                  mem_addr_d = {d[31:10], vaddr_q[19:12], 2'b00};
                  state_d    = L2;
               end
            end
         end
         L2: begin
            discard_d = flush_now;
            if (mem.mem_ready) begin
               res_domain = domain_q;
               res_field  = dacr_field(domain_access, domain_q);
               res_ap     = d[5:4];
               res_c      = d[3];
               res_b      = d[2];
               if (flush_now) begin
                  state_d   = DRAIN;
                  mem_req_d = 1'b0;
               end else if (mem.mem_abort) begin
                  res_fault  = 1'b1;
                  res_status = 4'hE;
               end else if (d[1:0] == 2'b00 || d[1:0] == 2'b11) begin
                  res_fault  = 1'b1;
                  res_status = 4'h7;
               end else if (!res_field[0]) begin
                  res_fault  = 1'b1;
                  res_status = 4'hB;
               end else if (d[1:0] == 2'b01) begin
                  res_fill  = 1'b1;
                  res_paddr = {d[31:16], 16'b0};
                  res_size  = 2'b01;
               end else begin
                  res_fill  = 1'b1;
                  res_paddr = {d[31:12], 12'b0};
                  res_size  = 2'b10;
               end
            end
         end
         RESP:    state_d = IDLE;
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Results are registered into RESP so the pulse and its fields appear together.
      if (res_fill || res_fault) begin
         state_d      = RESP;
         mem_req_d    = 1'b0;
         walk_count_d = walk_count_q + 32'd1;
      end
      if (res_fill) begin
         fill_valid_d  = 1'b1;
         fill_vaddr_d  = vaddr_q;
         fill_paddr_d  = res_paddr;
         fill_size_d   = res_size;
         fill_ap_d     = res_ap;
         fill_domain_d = res_domain;
         fill_mgr_d    = (res_field == 2'b11);
         fill_c_d      = res_c;
         fill_b_d      = res_b;
         fill_asid_d   = asid_q;
      end
      if (res_fault) begin
         fault_valid_d  = 1'b1;
         fault_status_d = res_status;
         fault_addr_d   = vaddr_q;
         fault_count_d  = fault_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         vaddr_q        <= '0;
         asid_q         <= '0;
         domain_q       <= '0;
         discard_q      <= 1'b0;
         mem_req_q      <= 1'b0;
         mem_addr_q     <= '0;
         fill_valid_q   <= 1'b0;
         fill_vaddr_q   <= '0;
         fill_paddr_q   <= '0;
         fill_size_q    <= '0;
         fill_ap_q      <= '0;
         fill_domain_q  <= '0;
         fill_mgr_q     <= 1'b0;
         fill_c_q       <= 1'b0;
         fill_b_q       <= 1'b0;
         fill_asid_q    <= '0;
         fault_valid_q  <= 1'b0;
         fault_status_q <= '0;
         fault_addr_q   <= '0;
         walk_count_q   <= '0;
         fault_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         vaddr_q        <= vaddr_d;
         asid_q         <= asid_d;
         domain_q       <= domain_d;
         discard_q      <= discard_d;
         mem_req_q      <= mem_req_d;
         mem_addr_q     <= mem_addr_d;
         fill_valid_q   <= fill_valid_d;
         fill_vaddr_q   <= fill_vaddr_d;
         fill_paddr_q   <= fill_paddr_d;
         fill_size_q    <= fill_size_d;
         fill_ap_q      <= fill_ap_d;
         fill_domain_q  <= fill_domain_d;
         fill_mgr_q     <= fill_mgr_d;
         fill_c_q       <= fill_c_d;
         fill_b_q       <= fill_b_d;
         fill_asid_q    <= fill_asid_d;
         fault_valid_q  <= fault_valid_d;
         fault_status_q <= fault_status_d;
         fault_addr_q   <= fault_addr_d;
         walk_count_q   <= walk_count_d;
         fault_count_q  <= fault_count_d;
      end
   end

   assign walk_ready   = (state_q == IDLE);
   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;
   assign fill_valid   = fill_valid_q;
   assign fill_vaddr   = fill_vaddr_q;
   assign fill_paddr   = fill_paddr_q;
   assign fill_size    = fill_size_q;
   assign fill_ap      = fill_ap_q;
   assign fill_domain  = fill_domain_q;
   assign fill_mgr     = fill_mgr_q;
   assign fill_c       = fill_c_q;
   assign fill_b       = fill_b_q;
   assign fill_asid    = fill_asid_q;
   assign fault_valid  = fault_valid_q;
   assign fault_status = fault_status_q;
   assign fault_addr   = fault_addr_q;
   assign walk_count   = walk_count_q;
   assign fault_count  = fault_count_q;

endmodule

// File: tb/tb_arm7tdmi_ptw.sv
// Directed bench for arm7tdmi_ptw: section/page fills, each fault class, flush with
// memory wait states, and reset in the middle of a walk.
module tb_arm7tdmi_ptw;

   logic        clk;
   logic        rst;
   logic        walk_req;
   logic        walk_ready;
   logic [31:0] walk_vaddr;
   logic [7:0]  walk_asid;
   logic [31:0] ttb_base;
   logic [31:0] domain_access;
   logic        walk_flush;
   logic        fill_valid;
   logic [31:0] fill_vaddr;
   logic [31:0] fill_paddr;
   logic [1:0]  fill_size;
   logic [1:0]  fill_ap;
   logic [3:0]  fill_domain;
   logic        fill_mgr;
   logic        fill_c;
   logic        fill_b;
   logic [7:0]  fill_asid;
   logic        fault_valid;
   logic [3:0]  fault_status;
   logic [31:0] fault_addr;
   logic [31:0] walk_count;
   logic [31:0] fault_count;

   int checks = 0;
   int errors = 0;

   arm7tdmi_ptw_if mem_bus ();

   arm7tdmi_ptw dut (
      .clk           (clk),
      .rst           (rst),
      .walk_req      (walk_req),
      .walk_ready    (walk_ready),
      .walk_vaddr    (walk_vaddr),
      .walk_asid     (walk_asid),
      .ttb_base      (ttb_base),
      .domain_access (domain_access),
      .walk_flush    (walk_flush),
      .mem           (mem_bus),
      .fill_valid    (fill_valid),
      .fill_vaddr    (fill_vaddr),
      .fill_paddr    (fill_paddr),
      .fill_size     (fill_size),
      .fill_ap       (fill_ap),
      .fill_domain   (fill_domain),
      .fill_mgr      (fill_mgr),
      .fill_c        (fill_c),
      .fill_b        (fill_b),
      .fill_asid     (fill_asid),
      .fault_valid   (fault_valid),
      .fault_status  (fault_status),
      .fault_addr    (fault_addr),
      .walk_count    (walk_count),
      .fault_count   (fault_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then land 1ns after the edge that sampled them.
   task automatic applyStimulus(input logic req, input logic rdy, input logic [31:0] rdata,
                                input logic abort, input logic flush);
      walk_req          = req;
      mem_bus.mem_ready = rdy;
      mem_bus.mem_rdata = rdata;
      mem_bus.mem_abort = abort;
      walk_flush        = flush;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      rst               = 1'b1;
      walk_req          = 1'b0;
      walk_vaddr        = 32'h1234_5678;
      walk_asid         = 8'h5A;
      ttb_base          = 32'h0001_0000;
      domain_access     = 32'h0000_0001;
      walk_flush        = 1'b0;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      mem_bus.mem_abort = 1'b0;

      // Reset state
      applyStimulus(0, 0, 32'h0, 0, 0);
      checkOutput("rst_ready", walk_ready, 1);
      checkOutput("rst_mem_req", mem_bus.mem_req, 0);
      checkOutput("rst_mem_addr", mem_bus.mem_addr, 0);
      checkOutput("rst_fill_valid", fill_valid, 0);
      checkOutput("rst_fault_valid", fault_valid, 0);
      checkOutput("rst_walk_count", walk_count, 0);
      rst = 1'b0;
      applyStimulus(0, 0, 32'h0, 0, 0);

      // Section walk: result 2 cycles after accept
      $display("[TB] section walk");
      applyStimulus(1, 0, 32'h0, 0, 0);
      checkOutput("sec_mem_req", mem_bus.mem_req, 1);
      checkOutput("sec_mem_addr", mem_bus.mem_addr, 32'h0001_048C);
      checkOutput("sec_busy", walk_ready, 0);
      checkOutput("sec_no_early_fill", fill_valid, 0);
      applyStimulus(0, 1, 32'h8765_0C0E, 0, 0);
      checkOutput("sec_fill_valid", fill_valid, 1);
      checkOutput("sec_fault_valid", fault_valid, 0);
      checkOutput("sec_paddr", fill_paddr, 32'h8760_0000);
      checkOutput("sec_size", fill_size, 2'b00);
      checkOutput("sec_ap", fill_ap, 2'b11);
      checkOutput("sec_c", fill_c, 1);
      checkOutput("sec_b", fill_b, 1);
      checkOutput("sec_domain", fill_domain, 0);
      checkOutput("sec_mgr", fill_mgr, 0);
      checkOutput("sec_vaddr", fill_vaddr, 32'h1234_5678);
      checkOutput("sec_asid", fill_asid, 8'h5A);
      checkOutput("sec_mem_req_drop", mem_bus.mem_req, 0);
      checkOutput("sec_walk_count", walk_count, 1);
      applyStimulus(0, 0, 32'h0, 0, 0);
      checkOutput("sec_pulse_end", fill_valid, 0);
      checkOutput("sec_ready_back", walk_ready, 1);

      // Coarse L1 + small page: result 3 cycles after accept
      $display("[TB] small page walk");
      walk_asid = 8'hA7;
      applyStimulus(1, 0, 32'h0, 0, 0);
      checkOutput("small_l1_addr", mem_bus.mem_addr, 32'h0001_048C);
      applyStimulus(0, 1, 32'h0002_0001, 0, 0);
      checkOutput("small_l2_addr", mem_bus.mem_addr, 32'h0002_0114);
      checkOutput("small_l2_req", mem_bus.mem_req, 1);
      checkOutput("small_no_early_fill", fill_valid, 0);
      applyStimulus(0, 1, 32'hABCD_E03A, 0, 0);
      checkOutput("small_fill_valid", fill_valid, 1);
      checkOutput("small_paddr", fill_paddr, 32'hABCD_E000);
      checkOutput("small_size", fill_size, 2'b10);
      checkOutput("small_ap", fill_ap, 2'b11);
      checkOutput("small_c", fill_c, 1);
      checkOutput("small_b", fill_b, 0);
      checkOutput("small_asid", fill_asid, 8'hA7);
      checkOutput("small_walk_count", walk_count, 2);
      applyStimulus(0, 0, 32'h0, 0, 0);

      // L1 invalid descriptor -> translation fault
      $display("[TB] L1 invalid fault");
      applyStimulus(1, 0, 32'h0, 0, 0);
      applyStimulus(0, 1, 32'h0000_0000, 0, 0);
      checkOutput("l1inv_fault_valid", fault_valid, 1);
      checkOutput("l1inv_fill_valid", fill_valid, 0);
      checkOutput("l1inv_status", fault_status, 4'h5);
      checkOutput("l1inv_addr", fault_addr, 32'h1234_5678);
      checkOutput("l1inv_fault_count", fault_count, 1);
      checkOutput("l1inv_walk_count", walk_count, 3);
      checkOutput("l1inv_fill_hold", fill_paddr, 32'hABCD_E000);
      applyStimulus(0, 0, 32'h0, 0, 0);
      checkOutput("l1inv_pulse_end", fault_valid, 0);

      // Section in domain 1 with no access -> section domain fault
      $display("[TB] section domain fault");
      domain_access = 32'h0;
      applyStimulus(1, 0, 32'h0, 0, 0);
      applyStimulus(0, 1, 32'h0000_0022, 0, 0);
      checkOutput("secdom_fault_valid", fault_valid, 1);
      checkOutput("secdom_status", fault_status, 4'h9);
      checkOutput("secdom_fault_count", fault_count, 2);
      applyStimulus(0, 0, 32'h0, 0, 0);

      // External abort on L2 fetch
      $display("[TB] L2 abort");
      domain_access = 32'h1;
      applyStimulus(1, 0, 32'h0, 0, 0);
      applyStimulus(0, 1, 32'h0002_0001, 0, 0);
      applyStimulus(0, 1, 32'hABCD_E03A, 1, 0);
      checkOutput("l2abt_fault_valid", fault_valid, 1);
      checkOutput("l2abt_fill_valid", fill_valid, 0);
      checkOutput("l2abt_status", fault_status, 4'hE);
      checkOutput("l2abt_walk_count", walk_count, 5);
      applyStimulus(0, 0, 32'h0, 0, 0);

      // Large page in domain 2 with reserved DACR value -> page domain fault
      $display("[TB] page domain fault");
      domain_access = 32'h0000_0020;
      applyStimulus(1, 0, 32'h0, 0, 0);
      applyStimulus(0, 1, 32'h0002_0041, 0, 0);
      applyStimulus(0, 1, 32'h1234_0001, 0, 0);
      checkOutput("pgdom_fault_valid", fault_valid, 1);
      checkOutput("pgdom_status", fault_status, 4'hB);
      checkOutput("pgdom_fault_count", fault_count, 4);
      applyStimulus(0, 0, 32'h0, 0, 0);

      // Large page in domain 2 as manager
      $display("[TB] large page manager");
      domain_access = 32'h0000_0030;
      applyStimulus(1, 0, 32'h0, 0, 0);
      applyStimulus(0, 1, 32'h0002_0041, 0, 0);
      applyStimulus(0, 1, 32'h1234_001D, 0, 0);
      checkOutput("large_fill_valid", fill_valid, 1);
      checkOutput("large_paddr", fill_paddr, 32'h1234_0000);
      checkOutput("large_size", fill_size, 2'b01);
      checkOutput("large_ap", fill_ap, 2'b01);
      checkOutput("large_domain", fill_domain, 4'h2);
      checkOutput("large_mgr", fill_mgr, 1);
      checkOutput("large_cb", {fill_c, fill_b}, 2'b11);
      checkOutput("large_walk_count", walk_count, 7);
      applyStimulus(0, 0, 32'h0, 0, 0);

      // Flush during an L1 fetch with three wait states
      $display("[TB] flush with wait states");
      domain_access = 32'h1;
      applyStimulus(1, 0, 32'h0, 0, 0);
      applyStimulus(0, 0, 32'h0, 0, 1);
      checkOutput("flush_req_w1", mem_bus.mem_req, 1);
      checkOutput("flush_addr_w1", mem_bus.mem_addr, 32'h0001_048C);
      applyStimulus(0, 0, 32'h0, 0, 0);
      checkOutput("flush_req_w2", mem_bus.mem_req, 1);
      applyStimulus(0, 0, 32'h0, 0, 0);
      checkOutput("flush_req_w3", mem_bus.mem_req, 1);
      checkOutput("flush_addr_w3", mem_bus.mem_addr, 32'h0001_048C);
      applyStimulus(0, 1, 32'h8765_0C0E, 0, 0);
      checkOutput("flush_req_drop", mem_bus.mem_req, 0);
      checkOutput("flush_no_fill", fill_valid, 0);
      checkOutput("flush_no_fault", fault_valid, 0);
      checkOutput("flush_drain_busy", walk_ready, 0);
      applyStimulus(0, 0, 32'h0, 0, 0);
      checkOutput("flush_ready_back", walk_ready, 1);
      checkOutput("flush_no_fill2", fill_valid, 0);
      checkOutput("flush_walk_count", walk_count, 7);
      checkOutput("flush_fault_count", fault_count, 4);

      // Reset while the L2 fetch is outstanding
      $display("[TB] reset mid-walk");
      applyStimulus(1, 0, 32'h0, 0, 0);
      applyStimulus(0, 1, 32'h0002_0001, 0, 0);
      checkOutput("rstw_in_l2", mem_bus.mem_req, 1);
      rst = 1'b1;
      applyStimulus(0, 0, 32'h0, 0, 0);
      rst = 1'b0;
      checkOutput("rstw_mem_req", mem_bus.mem_req, 0);
      checkOutput("rstw_ready", walk_ready, 1);
      checkOutput("rstw_mem_addr", mem_bus.mem_addr, 0);
      checkOutput("rstw_fill_paddr", fill_paddr, 0);
      checkOutput("rstw_walk_count", walk_count, 0);
      checkOutput("rstw_fault_count", fault_count, 0);
      applyStimulus(0, 1, 32'hABCD_E03A, 0, 0);
      checkOutput("rstw_late_fill", fill_valid, 0);
      checkOutput("rstw_late_fault", fault_valid, 0);
      checkOutput("rstw_late_ready", walk_ready, 1);
      applyStimulus(0, 0, 32'h0, 0, 0);
      checkOutput("rstw_late_fill2", fill_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arm7tdmi_ptw.md
Name: arm7tdmi_ptw

Overview:
Hardware page-table walker that services TLB misses from arm7tdmi_mmu. It takes a miss (vaddr, ASID), performs the ARMv4 two-level descriptor fetch from memory (L1 section/coarse, L2 large/small page) and checks the domain. It returns either a one-cycle TLB fill or a one-cycle fault with an FSR-style status.

Parameters:
ADDR_WIDTH, 32, virtual/physical address width (only 32 supported)
ASID_WIDTH, 8, ASID width carried through to the fill

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
walk_req  in  1  miss request; accepted when walk_req && walk_ready
walk_ready  out  1  high exactly when state==IDLE
walk_vaddr  in  32  faulting virtual address
walk_asid  in  8  ASID of the miss
ttb_base  in  32  translation table base; bits [13:0] ignored
domain_access  in  32  DACR, 2 bits per domain (domain D = bits [2D+1:2D])
walk_flush  in  1  TLB flush during walk; discard result
mem_req  out  1  descriptor read request
mem_addr  out  32  descriptor word address
mem_rdata  in  32  descriptor data, valid when mem_ready
mem_ready  in  1  read handshake complete
mem_abort  in  1  external abort, valid with mem_ready
fill_valid  out  1  one-cycle TLB fill pulse
fill_vaddr  out  32  captured walk_vaddr
fill_paddr  out  32  physical page base, low bits zero
fill_size  out  2  00 section 1MB, 01 large 64KB, 10 small 4KB
fill_ap  out  2  access permission
fill_domain  out  4  domain number
fill_mgr  out  1  domain is manager (DACR=11)
fill_c  out  1  cacheable
fill_b  out  1  bufferable
fill_asid  out  8  captured walk_asid
fault_valid  out  1  one-cycle fault pulse
fault_status  out  4  FSR code
fault_addr  out  32  captured walk_vaddr
walk_count  out  32  completed walks (fill or fault), wraps
fault_count  out  32  faults reported, wraps

Behaviour:
- States: IDLE, L1, L2, RESP, DRAIN.
- Reset: state=IDLE; mem_req, fill_valid, fault_valid=0; all captured fields, counters, mem_addr=0. Reset mid-walk returns to IDLE at once and drops mem_req; any later mem_ready is ignored.
- IDLE: on accept, capture vaddr/asid. Go to L1 with mem_addr={ttb_base[31:14], vaddr[31:20], 2'b00}.
- L1/L2: mem_req=1; mem_addr stable until the first cycle with mem_ready=1, when mem_rdata/mem_abort are sampled.
- L1 decode (d=mem_rdata):
  - mem_abort: fault 0xC.
  - d[1:0]=00 or 11 (fine table not supported): fault 0x5.
  - 10 section: domain=d[8:5]; DACR field 00/10: fault 0x9; else fill with paddr={d[31:20],20'b0}, ap=d[11:10], c=d[3], b=d[2], size=00.
  - 01 coarse: latch domain=d[8:5]; go to L2 with mem_addr={d[31:10], vaddr[19:12], 2'b00}.
- L2 decode:
  - mem_abort: fault 0xE.
  - d[1:0]=00 or 11 (tiny not supported): fault 0x7.
  - Domain check on latched domain: fault 0xB.
  - 01 large: paddr={d[31:16],16'b0}, size=01.
  - 10 small: paddr={d[31:12],12'b0}, size=10.
  - Pages: ap=d[5:4] (AP0 only, subpages not supported); c=d[3], b=d[2].
- RESP: fill_valid or fault_valid high for exactly one cycle (never both); walk_count++, and fault_count++ on fault; then IDLE. Fill/fault fields hold until the next result.
- Latency with zero-wait memory: section result 2 cycles after accept; page result 3 cycles. Each memory wait cycle adds 1.
- walk_flush while in L1/L2: set discard. The outstanding read must still complete (mem_req held), then go to DRAIN → IDLE with no fill, no fault, and no counter change.
- walk_flush in IDLE or RESP: no effect; a RESP pulse still issues.
- walk_flush coincident with accept in IDLE: request accepted normally.
- walk_req ignored outside IDLE.

Test Plan:
- ttb_base=0x00010000, vaddr=0x12345678, L1@0x0001048C=0x8765_0C0E, DACR=0x1 → mem_addr 0x0001048C; fill_valid 2 cycles after accept, paddr=0x87600000, size=00, ap=11, c=1, b=1, domain=0, fill_mgr=0.
- Same vaddr, L1=0x00020001, L2@0x00020114=0xABCDE03A → second mem_addr 0x00020114; fill paddr=0xABCDE000, size=10, ap=11, c=1, b=0; 3 cycles.
- L1 descriptor 0x00000000 → fault_valid, status 0x5, fault_addr=0x12345678, fault_count=1. L1 section domain 1 with DACR=0x0 → status 0x9.
- Coarse walk, mem_abort on L2 → status 0xE. L2 large page with DACR for that domain=10 → status 0xB.
- 3 memory wait states on L1; pulse walk_flush in wait cycle 1 → mem_req held until mem_ready; no fill/fault; walk_count unchanged; walk_ready returns high.
- Assert rst during L2 → next cycle mem_req=0, walk_ready=1, outputs zero; a late mem_ready produces no pulse.
